// File: rtl/dsram_pkg.sv
// Shared types, constants and helpers for the data SRAM responder.
package dsram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Byte-lane merge: lanes with we[i]=1 take new_w, the rest keep old_w.
    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  we);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_array.sv
// Single-port DEPTH x 32 storage, byte-writable, registered read-first output.
// No reset: contents and the output register are only defined by accesses.
module dsram_array
    import dsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Enabled access: capture the old word, then commit the byte-merged word.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q  <= mem[idx];
            mem[idx] <= merge(mem[idx], wdata, we);
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: post-reset clear, range check, 1-cycle read data,
// saturating access counters.
//
// state    | meaning
// ST_INIT  | zeroing word clr_idx each cycle, requests ignored
// ST_READY | serving requests until the next reset
module data_sram_responder
    import dsram_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        sram_ready,
    output logic        addr_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
    localparam state_t ST_RESET = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  sel_arr_q, sel_arr_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;

    logic [31:0]           off;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  accept;
    logic                  is_write;

    logic                  arr_en;
    logic [3:0]            arr_we;
    logic [ADDR_WIDTH-1:0] arr_idx;
    logic [31:0]           arr_wdata;
    logic [31:0]           arr_rdata;

    assign off      = data_sram_addr - BASE_ADDR;
    assign in_range = ((off >> (ADDR_WIDTH + 2)) == 32'd0);
    assign req_idx  = off[ADDR_WIDTH+1:2];
    assign accept   = (state_q == ST_READY) && data_sram_en;
    assign is_write = (data_sram_we != 4'b0000);

    // Array port: clear writes own it during INIT, in-range requests afterwards.
    always_comb begin
        arr_en    = accept && in_range;
        arr_we    = data_sram_we;
        arr_idx   = req_idx;
        arr_wdata = data_sram_wdata;
        if (state_q == ST_INIT) begin
            arr_en    = 1'b1;
            arr_we    = 4'b1111;
            arr_idx   = clr_idx_q;
            arr_wdata = 32'h0;
        end
    end

    // Next-state: clear sequencing, sticky error, output source, counters.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        err_d     = err_q;
        sel_arr_d = sel_arr_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        if (state_q == ST_INIT) begin
            clr_idx_d = clr_idx_q + IDX_ONE;
            if (clr_idx_q == IDX_LAST) begin
                state_d = ST_READY;
            end
        end
        if (accept) begin
            // Out-of-range responses return zero; in-range ones come from the array.
            sel_arr_d = in_range;
            if (!in_range) begin
                err_d = 1'b1;
            end
            if (is_write) begin
                wr_cnt_d = (wr_cnt_q == CNT_MAX) ? wr_cnt_q : wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_d = (rd_cnt_q == CNT_MAX) ? rd_cnt_q : rd_cnt_q + 32'd1;
            end
        end
        ready_d = (state_d == ST_READY);
    end

    // FSM and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_RESET;
            clr_idx_q <= '0;
            ready_q   <= (ST_RESET == ST_READY);
            err_q     <= 1'b0;
            sel_arr_q <= 1'b0;
            rd_cnt_q  <= 32'h0;
            wr_cnt_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            sel_arr_q <= sel_arr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    dsram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // The array register holds between its accesses, so selecting it gives the
    // stall-hold behaviour; reset forces the zero source asynchronously.
    assign data_sram_rdata = sel_arr_q ? arr_rdata : 32'h0;
    assign sram_ready      = ready_q;
    assign addr_err        = err_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    localparam int          AW   = 4;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        aerr;
    logic [31:0] rdc;
    logic [31:0] wrc;

    int total;
    int bad;
    int cyc;

    data_sram_responder #(
        .ADDR_WIDTH     (AW),
        .BASE_ADDR      (BASE),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .sram_ready      (ready),
        .addr_err        (aerr),
        .rd_cnt          (rdc),
        .wr_cnt          (wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request over one clock edge; outputs sampled 1 ns after the edge.
    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en    = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from reset release until sram_ready; optionally issues a
    // write during the second INIT cycle that must be ignored.
    task automatic wait_ready(input bit inject);
        cyc = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            cyc = n;
            if (ready) break;
            if (inject && n == 1) begin
                en = 1'b1; we = 4'b1111; addr = BASE; wdata = 32'hFFFF_FFFF;
            end
            if (inject && n == 2) begin
                en = 1'b0;
                chk("init_rdata_hold", rdata, 32'h0);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetn = 1'b0;
        en     = 1'b0;
        we     = 4'b0000;
        addr   = 32'h0;
        wdata  = 32'h0;

        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_aerr", {31'h0, aerr}, 32'h0);
        chk("rst_rdcnt", rdc, 32'h0);
        chk("rst_wrcnt", wrc, 32'h0);

        // Clear sequence, with an ignored write during INIT.
        @(negedge clk);
        resetn = 1'b1;
        wait_ready(1'b1);
        chk("init_len", 32'(cyc), 32'd16);
        chk("init_wrcnt", wrc, 32'h0);

        for (int i = 0; i < 16; i++) begin
            req(4'b0000, BASE + 32'(4 * i), 32'h0);
            chk($sformatf("clr_word%0d", i), rdata, 32'h0);
        end
        idle();
        chk("clr_rdcnt", rdc, 32'd16);

        // Byte-lane writes.
        req(4'b1111, BASE + 32'h8, 32'hDEAD_BEEF);
        chk("wr1_readfirst", rdata, 32'h0);
        req(4'b0101, BASE + 32'h8, 32'h1122_3344);
        chk("wr2_readfirst", rdata, 32'hDEAD_BEEF);
        req(4'b0000, BASE + 32'h8, 32'h0);
        chk("byte_merge", rdata, 32'hDE22_BE44);
        idle();
        chk("bm_wrcnt", wrc, 32'd2);
        chk("bm_rdcnt", rdc, 32'd17);

        // Read-first and hold across stalls (store enables with en=0 ignored).
        req(4'b1111, BASE + 32'h4, 32'hA5A5_A5A5);
        req(4'b1111, BASE + 32'h4, 32'h1234_5678);
        chk("readfirst", rdata, 32'hA5A5_A5A5);
        for (int i = 0; i < 3; i++) begin
            en = 1'b0; we = 4'b1111; addr = BASE + 32'h4; wdata = 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d", i), rdata, 32'hA5A5_A5A5);
        end
        req(4'b0000, BASE + 32'h4, 32'h0);
        chk("after_hold", rdata, 32'h1234_5678);

        // Back-to-back write then read of the same word.
        req(4'b1111, BASE + 32'hC, 32'hCAFE_F00D);
        req(4'b0000, BASE + 32'hC, 32'h0);
        chk("raw_b2b", rdata, 32'hCAFE_F00D);
        idle();
        chk("mid_wrcnt", wrc, 32'd5);
        chk("mid_rdcnt", rdc, 32'd19);
        chk("aerr_clean", {31'h0, aerr}, 32'h0);

        // Range checks around the window edges.
        req(4'b0000, BASE + 32'h40, 32'h0);
        chk("oor_rdata", rdata, 32'h0);
        chk("oor_aerr", {31'h0, aerr}, 32'h1);
        chk("oor_rdcnt", rdc, 32'd20);
        req(4'b1111, 32'h1BFF_FFFC, 32'h7777_7777);
        chk("oor_wrcnt", wrc, 32'd6);
        req(4'b0000, BASE + 32'h3C, 32'h0);
        chk("top_word_untouched", rdata, 32'h0);
        req(4'b0000, BASE + 32'h0, 32'h0);
        chk("word0_untouched", rdata, 32'h0);
        idle();
        chk("aerr_sticky", {31'h0, aerr}, 32'h1);

        // Asynchronous reset in the middle of back-to-back reads.
        req(4'b0000, BASE + 32'h8, 32'h0);
        chk("pre_rst_rdata", rdata, 32'hDE22_BE44);
        addr = BASE + 32'h4;
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_rdata", rdata, 32'h0);
        chk("arst_rdcnt", rdc, 32'h0);
        chk("arst_wrcnt", wrc, 32'h0);
        chk("arst_aerr", {31'h0, aerr}, 32'h0);
        chk("arst_ready", {31'h0, ready}, 32'h0);
        en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        wait_ready(1'b0);
        chk("reinit_len", 32'(cyc), 32'd16);
        req(4'b0000, BASE + 32'h8, 32'h0);
        chk("reclr_w2", rdata, 32'h0);
        req(4'b0000, BASE + 32'h4, 32'h0);
        chk("reclr_w1", rdata, 32'h0);
        req(4'b0000, BASE + 32'hC, 32'h0);
        chk("reclr_w3", rdata, 32'h0);
        idle();
        chk("reclr_rdcnt", rdc, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
Memory-side responder for the data SRAM request port driven by the execute stage (en / we / addr / wdata). Holds the data storage and returns read data with fixed 1-cycle latency, so the memory stage samples data_sram_rdata the cycle after the request. Adds a post-reset clear sequence, range checking and access counters for bring-up and verification. Sits at the CPU top beside the instruction SRAM.

Parameters:
ADDR_WIDTH, 10, number of word-index bits; DEPTH = 2**ADDR_WIDTH 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word-aligned).
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = go straight to READY.

Ports:
clk  in  1  clock, all state on rising edge.
resetn  in  1  asynchronous, active-low reset.
data_sram_en  in  1  request valid (load or store).
data_sram_we  in  4  byte write enables; 4'b0000 = read.
data_sram_addr  in  32  byte address; bits [1:0] ignored.
data_sram_wdata  in  32  store data, byte i = wdata[8i+7:8i].
data_sram_rdata  out  32  read data, valid the cycle after an accepted request.
sram_ready  out  1  1 in READY state; 0 while clearing.
addr_err  out  1  sticky: an accepted request was out of range.
rd_cnt  out  32  accepted reads, saturating.
wr_cnt  out  32  accepted writes, saturating.

Behaviour:
- Reset (resetn low, asynchronous, also mid-operation): rdata=0, addr_err=0, rd_cnt=wr_cnt=0, clr_idx=0. State = INIT if CLEAR_ON_RESET, else READY. Storage contents are not reset directly.
- FSM INIT:
  - Each cycle writes 32'h0 to word clr_idx, then clr_idx++.
  - After writing word DEPTH-1, go to READY. INIT lasts exactly DEPTH cycles.
  - sram_ready=0. Requests are ignored: no write, rdata holds, counters and addr_err unchanged.
- FSM READY: terminal until the next reset. sram_ready=1 (registered; rises the cycle after the last clear write).
- Index: off = addr - BASE_ADDR (32-bit wrap). In range iff off[31:ADDR_WIDTH+2] == 0. idx = off[ADDR_WIDTH+1:2].
- Accepted request: READY && en.
- In-range write (we != 0): at the clock edge, bytes with we[i]=1 update and the others keep their value. rdata <= the word before the write (read-first). wr_cnt++.
- In-range read (we == 0): rdata <= mem[idx]. rd_cnt++.
- Out of range: no storage change. rdata <= 0. addr_err <= 1. The matching counter still increments.
- en=0 (or not accepted): rdata holds its previous value. This allows the consumer to stall.
- we != 0 with en=0: ignored.
- Back-to-back read-after-write to the same word: the read in cycle N+1 returns the data written in cycle N (no bypass needed, write commits at edge N).
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Latency is always exactly 1 cycle. There is no backpressure to the initiator. The CPU top gates the pipeline with sram_ready.

Decomposition:
- Shared package dsram_pkg:
  - state typedef (INIT, READY)
  - CNT_MAX constant
  - byte-merge function: merge(old, new, we) returns a 32-bit word
- One natural sub-module, dsram_array: DEPTH x 32 storage with a single port.
  - Inputs: clk, en, we[3:0], idx, wdata.
  - Output: rdata registered read-first.
  - The responder muxes the clear port versus the request port into it.
  - No reset inside the array.

Test Plan:
1. Reset clear, ADDR_WIDTH=4: release resetn → sram_ready=0 for 16 cycles then 1. Read every word → rdata=0. rd_cnt=16.
2. Byte write: write addr 0x8, we=4'b1111, wdata=0xDEADBEEF. Then write we=4'b0101, wdata=0x11223344. Read 0x8 → next cycle rdata=0xDE22BE44. wr_cnt=2, rd_cnt=1.
3. Read-first and hold: word 0x4=0xA5A5A5A5. Write 0x4 with 0x12345678 → rdata=0xA5A5A5A5. Drop en for 3 cycles → rdata stays 0xA5A5A5A5. Read 0x4 → 0x12345678.
4. Range, BASE_ADDR=0x1C000000, ADDR_WIDTH=4:
   - Read 0x1C000040 → rdata=0, addr_err=1, rd_cnt increments.
   - Store 0x1BFFFFFC → storage unchanged.
   - addr_err stays 1 until reset.
5. Requests in INIT: issue write 0x0=0xFFFFFFFF in cycle 2 of INIT → after READY, read 0x0 gives 0. wr_cnt=0.
6. Mid-operation reset: assert resetn=0 during back-to-back accesses → rdata, counters and addr_err go 0 immediately (asynchronous). INIT restarts from clr_idx=0 and all words read 0 afterwards.
